// File: rtl/dcache_data_array_if.sv
// Bundle of CPU access, line-refill and line-eviction signals of the D-cache data array.
// The master side is the cache controller or bus; the slave side is the data array.
interface dcache_data_array_if #(
    parameter int unsigned NUM_WAYS       = 2,
    parameter int unsigned NUM_SETS       = 64,
    parameter int unsigned WORDS_PER_LINE = 16,
    parameter int unsigned WORD_WIDTH     = 32
);
    localparam int unsigned WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned INDEX_W   = $clog2(NUM_SETS);
    localparam int unsigned OFFSET_W  = $clog2(WORDS_PER_LINE);
    localparam int unsigned NUM_BYTES = WORD_WIDTH / 8;

    // CPU word access
    logic                  req_valid;
    logic                  req_ready;
    logic [WAY_W-1:0]      req_way;
    logic [INDEX_W-1:0]    req_index;
    logic [OFFSET_W-1:0]   req_offset;
    logic [NUM_BYTES-1:0]  req_strobe;
    logic [WORD_WIDTH-1:0] req_wdata;
    logic                  rdata_valid;
    logic [WORD_WIDTH-1:0] rdata;

    // Line transfer control
    logic                  fill_start;
    logic                  evict_start;
    logic [WAY_W-1:0]      xfer_way;
    logic [INDEX_W-1:0]    xfer_index;

    // Refill beats from the bus
    logic                  fill_valid;
    logic [WORD_WIDTH-1:0] fill_data;
    logic                  fill_ready;
    logic                  fill_done;

    // Eviction beats to the write-back buffer
    logic                  evict_valid;
    logic [WORD_WIDTH-1:0] evict_data;
    logic                  evict_last;
    logic                  evict_ready;

    logic                  busy;

    modport master (
        output req_valid, req_way, req_index, req_offset, req_strobe, req_wdata,
        input  req_ready, rdata_valid, rdata,
        output fill_start, evict_start, xfer_way, xfer_index,
        output fill_valid, fill_data,
        input  fill_ready, fill_done,
        input  evict_valid, evict_data, evict_last,
        output evict_ready,
        input  busy
    );

    modport slave (
        input  req_valid, req_way, req_index, req_offset, req_strobe, req_wdata,
        output req_ready, rdata_valid, rdata,
        input  fill_start, evict_start, xfer_way, xfer_index,
        input  fill_valid, fill_data,
        output fill_ready, fill_done,
        output evict_valid, evict_data, evict_last,
        input  evict_ready,
        output busy
    );
endinterface

// File: rtl/dcache_data_array.sv
// Multi-way D-cache data store: read-first CPU word port plus a serialising FSM that
// refills a line from the bus or evicts a line to the write-back buffer, one word per beat.
module dcache_data_array #(
    parameter int unsigned NUM_WAYS       = 2,
    parameter int unsigned NUM_SETS       = 64,
    parameter int unsigned WORDS_PER_LINE = 16,
    parameter int unsigned WORD_WIDTH     = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    dcache_data_array_if.slave   bus
);
    localparam int unsigned WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned INDEX_W   = $clog2(NUM_SETS);
    localparam int unsigned OFFSET_W  = $clog2(WORDS_PER_LINE);
    localparam int unsigned NUM_BYTES = WORD_WIDTH / 8;
    localparam int unsigned ADDR_W    = WAY_W + INDEX_W + OFFSET_W;
    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam logic [OFFSET_W-1:0] LAST_OFF = OFFSET_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_EVICT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [OFFSET_W-1:0]   r_cnt;
    logic [OFFSET_W-1:0]   w_cnt_nxt;
    logic [WAY_W-1:0]      r_way;
    logic [INDEX_W-1:0]    r_index;

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];

    logic                  r_rdata_valid;
    logic [WORD_WIDTH-1:0] r_rdata;
    logic                  r_fill_done;
    logic                  r_evict_valid;
    logic [WORD_WIDTH-1:0] r_evict_data;
    logic                  r_evict_last;

    logic                  w_req_ready_c;
    logic                  w_accept;
    logic                  w_latch;
    logic                  w_fill_we;
    logic                  w_fill_done_nxt;
    logic                  w_ev_load;
    logic                  w_ev_clear;
    logic [OFFSET_W-1:0]   w_ev_off;
    logic                  w_cpu_we;

    logic [ADDR_W-1:0]     w_cpu_addr;
    logic [ADDR_W-1:0]     w_fill_addr;
    logic [ADDR_W-1:0]     w_ev_addr;

    assign w_cpu_addr  = {bus.req_way, bus.req_index, bus.req_offset};
    assign w_fill_addr = {r_way, r_index, r_cnt};
    assign w_ev_addr   = {r_way, r_index, w_ev_off};
    assign w_cpu_we    = w_accept & (|bus.req_strobe) & ~i_reset;

    // Next state and per-cycle control strobes
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_req_ready_c   = 1'b0;
        w_accept        = 1'b0;
        w_latch         = 1'b0;
        w_fill_we       = 1'b0;
        w_fill_done_nxt = 1'b0;
        w_ev_load       = 1'b0;
        w_ev_clear      = 1'b0;
        w_ev_off        = r_cnt;

        unique case (r_state)
            S_IDLE: begin
                w_req_ready_c = ~bus.fill_start & ~bus.evict_start;
                if (bus.evict_start) begin
                    w_state_nxt = S_EVICT;
                    w_latch     = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (bus.fill_start) begin
                    w_state_nxt = S_FILL;
                    w_latch     = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_accept = bus.req_valid;
                end
            end
            S_FILL: begin
                if (bus.fill_valid) begin
                    w_fill_we = ~i_reset;
                    w_cnt_nxt = r_cnt + OFFSET_W'(1);
                    if (r_cnt == LAST_OFF) begin
                        w_state_nxt     = S_IDLE;
                        w_fill_done_nxt = 1'b1;
                    end
                end
            end
            S_EVICT: begin
                // First cycle in EVICT only fetches word 0; afterwards each handshake fetches the next
                if (!r_evict_valid) begin
                    w_ev_load = 1'b1;
                end else if (bus.evict_ready) begin
                    if (r_evict_last) begin
                        w_ev_clear  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + OFFSET_W'(1);
                        w_ev_off  = r_cnt + OFFSET_W'(1);
                        w_ev_load = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, transfer context and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_way         <= '0;
            r_index       <= '0;
            r_rdata_valid <= 1'b0;
            r_rdata       <= '0;
            r_fill_done   <= 1'b0;
            r_evict_valid <= 1'b0;
            r_evict_data  <= '0;
            r_evict_last  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rdata_valid <= w_accept;
            r_fill_done   <= w_fill_done_nxt;
            if (w_latch) begin
                r_way   <= bus.xfer_way;
                r_index <= bus.xfer_index;
            end
            if (w_accept) begin
                r_rdata <= r_mem[w_cpu_addr];
            end
            if (w_ev_load) begin
                r_evict_valid <= 1'b1;
                r_evict_data  <= r_mem[w_ev_addr];
                r_evict_last  <= (w_ev_off == LAST_OFF);
            end else if (w_ev_clear) begin
                r_evict_valid <= 1'b0;
                r_evict_last  <= 1'b0;
            end
        end
    end

    // Data RAM: not reset; CPU byte writes and refill word writes never coincide
    always_ff @(posedge i_clk) begin
        if (w_cpu_we) begin
            for (int b = 0; b < int'(NUM_BYTES); b++) begin
                if (bus.req_strobe[b]) begin
                    r_mem[w_cpu_addr][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
                end
            end
        end
        if (w_fill_we) begin
            r_mem[w_fill_addr] <= bus.fill_data;
        end
    end

    assign bus.req_ready   = w_req_ready_c;
    assign bus.rdata_valid = r_rdata_valid;
    assign bus.rdata       = r_rdata;
    assign bus.fill_ready  = (r_state == S_FILL);
    assign bus.fill_done   = r_fill_done;
    assign bus.evict_valid = r_evict_valid;
    assign bus.evict_data  = r_evict_data;
    assign bus.evict_last  = r_evict_last;
    assign bus.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_dcache_data_array.sv
// Randomised bench for dcache_data_array against a line/queue-level model of the data store,
// with directed sequences whose results are pinned to hand-computed literals.
module tb_dcache_data_array;
    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_EVICT = 2;

    logic clk;
    logic reset;

    dcache_data_array_if bus ();

    dcache_data_array dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // Model state
    logic [31:0] m_mem [2][64][16];
    int          mode      = M_IDLE;
    logic        fw;
    logic [5:0]  fi;
    int          fill_n;
    logic [31:0] ev_q [$];
    bit          known_ok  = 1'b0;
    bit          started   = 1'b0;

    // Expected registered outputs
    bit          exp_rv     = 1'b0;
    logic [31:0] exp_rdata  = '0;
    bit          exp_rknown = 1'b0;
    bit          exp_fd     = 1'b0;
    bit          exp_busy   = 1'b0;
    bit          exp_fr     = 1'b0;
    bit          exp_evv    = 1'b0;
    logic [31:0] exp_evd    = '0;
    bit          exp_evl    = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic idle_inputs();
        bus.req_valid   = 1'b0;
        bus.req_way     = '0;
        bus.req_index   = '0;
        bus.req_offset  = '0;
        bus.req_strobe  = '0;
        bus.req_wdata   = '0;
        bus.fill_start  = 1'b0;
        bus.evict_start = 1'b0;
        bus.xfer_way    = '0;
        bus.xfer_index  = '0;
        bus.fill_valid  = 1'b0;
        bus.fill_data   = '0;
        bus.evict_ready = 1'b0;
    endtask

    // One clock: capture driven inputs, pass the edge, then advance the model
    task automatic cycle();
        bit          r  = reset;
        bit          rv = bus.req_valid;
        logic        w  = bus.req_way;
        logic [5:0]  ix = bus.req_index;
        logic [3:0]  o  = bus.req_offset;
        logic [3:0]  st = bus.req_strobe;
        logic [31:0] wd = bus.req_wdata;
        bit          fs = bus.fill_start;
        bit          es = bus.evict_start;
        logic        xw = bus.xfer_way;
        logic [5:0]  xi = bus.xfer_index;
        bit          fv = bus.fill_valid;
        logic [31:0] fd = bus.fill_data;
        bit          er = bus.evict_ready;
        @(posedge clk);
        #1;
        exp_rv = 1'b0;
        exp_fd = 1'b0;
        if (r) begin
            mode      = M_IDLE;
            exp_rdata = '0;
            exp_evv   = 1'b0;
            exp_evd   = '0;
            exp_evl   = 1'b0;
            ev_q.delete();
        end else begin
            case (mode)
                M_IDLE: begin
                    if (es) begin
                        mode = M_EVICT;
                        ev_q.delete();
                        for (int i = 0; i < 16; i++) ev_q.push_back(m_mem[xw][xi][i]);
                    end else if (fs) begin
                        mode   = M_FILL;
                        fw     = xw;
                        fi     = xi;
                        fill_n = 0;
                    end else if (rv) begin
                        exp_rv     = 1'b1;
                        exp_rdata  = m_mem[w][ix][o];
                        exp_rknown = known_ok;
                        for (int b = 0; b < 4; b++)
                            if (st[b]) m_mem[w][ix][o][b*8 +: 8] = wd[b*8 +: 8];
                    end
                end
                M_FILL: begin
                    if (fv) begin
                        m_mem[fw][fi][fill_n] = fd;
                        fill_n++;
                        if (fill_n == 16) begin
                            mode   = M_IDLE;
                            exp_fd = 1'b1;
                        end
                    end
                end
                default: begin
                    if (!exp_evv) begin
                        exp_evv = 1'b1;
                        exp_evd = ev_q[0];
                        exp_evl = (ev_q.size() == 1);
                    end else if (er) begin
                        void'(ev_q.pop_front());
                        if (ev_q.size() == 0) begin
                            exp_evv = 1'b0;
                            exp_evl = 1'b0;
                            mode    = M_IDLE;
                        end else begin
                            exp_evd = ev_q[0];
                            exp_evl = (ev_q.size() == 1);
                        end
                    end
                end
            endcase
        end
        exp_busy = (mode != M_IDLE);
        exp_fr   = (mode == M_FILL);
        started  = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (started) begin
            chk("busy", bus.busy, exp_busy);
            chk("fill_ready", bus.fill_ready, exp_fr);
            chk("fill_done", bus.fill_done, exp_fd);
            chk("rdata_valid", bus.rdata_valid, exp_rv);
            if (exp_rv && exp_rknown) chk("rdata", bus.rdata, exp_rdata);
            chk("evict_valid", bus.evict_valid, exp_evv);
            chk("evict_last", bus.evict_last, exp_evl);
            if (exp_evv) chk("evict_data", bus.evict_data, exp_evd);
            chk("req_ready", bus.req_ready,
                (mode == M_IDLE) && !bus.fill_start && !bus.evict_start);
        end
    end

    task automatic cpu(input logic w, input logic [5:0] ix, input logic [3:0] o,
                       input logic [3:0] st, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_way    = w;
        bus.req_index  = ix;
        bus.req_offset = o;
        bus.req_strobe = st;
        bus.req_wdata  = wd;
        cycle();
        idle_inputs();
    endtask

    task automatic start_xfer(input bit ev, input logic w, input logic [5:0] ix);
        bus.evict_start = ev;
        bus.fill_start  = !ev;
        bus.xfer_way    = w;
        bus.xfer_index  = ix;
        cycle();
        idle_inputs();
    endtask

    // Run the current transfer to completion with random beats and ignored junk inputs
    task automatic drain(input int budget);
        int k = 0;
        while (mode != M_IDLE && k < budget) begin
            bus.fill_valid  = ($urandom_range(0, 2) != 0);
            bus.fill_data   = $urandom;
            bus.evict_ready = ($urandom_range(0, 2) != 0);
            bus.fill_start  = ($urandom_range(0, 7) == 0);
            bus.evict_start = ($urandom_range(0, 7) == 0);
            bus.xfer_way    = 1'($urandom);
            bus.xfer_index  = 6'($urandom);
            bus.req_valid   = ($urandom_range(0, 3) == 0);
            bus.req_strobe  = 4'($urandom);
            bus.req_offset  = 4'($urandom);
            cycle();
            k++;
        end
        idle_inputs();
        if (mode != M_IDLE) begin
            n_total++;
            $display("FAIL xfer_timeout: transfer still active after %0d cycles, required idle", budget);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, fdc, rrs;
        logic [31:0] evd [$];
        bit          evl [$];

        reset = 1'b1;
        idle_inputs();
        repeat (3) cycle();
        chk("rst_busy", bus.busy, 0);
        chk("rst_fill_ready", bus.fill_ready, 0);
        chk("rst_rdata_valid", bus.rdata_valid, 0);
        chk("rst_evict_valid", bus.evict_valid, 0);
        chk("rst_fill_done", bus.fill_done, 0);
        reset = 1'b0;

        // Give every RAM word a defined value
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 64; s++)
                for (int o = 0; o < 16; o++)
                    cpu(1'(w), 6'(s), 4'(o), 4'hF, $urandom);
        known_ok = 1'b1;
        cycle();

        // Byte-strobe write and read-first behaviour
        cpu(1'b1, 6'd5, 4'd3, 4'hF, 32'hDEADBEEF);
        cpu(1'b1, 6'd5, 4'd3, 4'h0, 32'h0);
        chk("rd_deadbeef_valid", bus.rdata_valid, 1);
        chk("rd_deadbeef", bus.rdata, 32'hDEADBEEF);
        cycle();
        chk("rdata_valid_one_cycle", bus.rdata_valid, 0);
        cpu(1'b1, 6'd5, 4'd3, 4'b0010, 32'h0000AA00);
        chk("wr_returns_old", bus.rdata, 32'hDEADBEEF);
        cpu(1'b1, 6'd5, 4'd3, 4'h0, 32'h0);
        chk("rd_merged", bus.rdata, 32'hDEADAAEF);

        // Gapped refill of way0/idx7 with CPU requests pending
        start_xfer(1'b0, 1'b0, 6'd7);
        nb = 0; fdc = 0; rrs = 0;
        for (int k = 0; k < 64 && nb < 16; k++) begin
            bus.fill_valid = (k % 2 == 0);
            bus.fill_data  = 32'(32'h100 + nb);
            bus.req_valid  = 1'b1;
            bus.req_offset = 4'($urandom);
            #1;
            if (bus.req_ready) rrs++;
            cycle();
            if (bus.fill_done) fdc++;
            if (k % 2 == 0) nb++;
        end
        idle_inputs();
        repeat (3) begin
            cycle();
            if (bus.fill_done) fdc++;
        end
        chk("fill_beats", nb, 16);
        chk("fill_done_pulses", fdc, 1);
        chk("req_ready_during_fill", rrs, 0);
        for (int i = 0; i < 16; i++) begin
            cpu(1'b0, 6'd7, 4'(i), 4'h0, 32'h0);
            chk("fill_readback", bus.rdata, 32'(32'h100 + i));
        end

        // Evict the same line with evict_ready toggling
        start_xfer(1'b1, 1'b0, 6'd7);
        for (int k = 0; k < 100 && evd.size() < 16; k++) begin
            bus.evict_ready = (k % 2 == 0);
            bus.fill_valid  = 1'b1;
            #1;
            if (bus.evict_valid && bus.evict_ready) begin
                evd.push_back(bus.evict_data);
                evl.push_back(bus.evict_last);
            end
            cycle();
        end
        idle_inputs();
        chk("evict_beats", evd.size(), 16);
        for (int i = 0; i < 16 && i < evd.size(); i++) begin
            chk("evict_word", evd[i], 32'(32'h100 + i));
            chk("evict_last_flag", evl[i], (i == 15));
        end
        cycle();
        chk("evict_done_idle", bus.busy, 0);

        // All three requests together: eviction wins
        bus.fill_start  = 1'b1;
        bus.evict_start = 1'b1;
        bus.req_valid   = 1'b1;
        bus.xfer_way    = 1'b1;
        bus.xfer_index  = 6'd9;
        #1;
        chk("req_ready_all_starts", bus.req_ready, 0);
        cycle();
        idle_inputs();
        chk("prio_busy", bus.busy, 1);
        chk("prio_not_fill", bus.fill_ready, 0);
        chk("prio_no_cpu", bus.rdata_valid, 0);
        drain(200);

        // Reset after five refill beats
        start_xfer(1'b0, 1'b0, 6'd7);
        for (int i = 0; i < 5; i++) begin
            bus.fill_valid = 1'b1;
            bus.fill_data  = 32'(32'h200 + i);
            cycle();
        end
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_fill_ready", bus.fill_ready, 0);
        for (int i = 0; i < 16; i++) begin
            cpu(1'b0, 6'd7, 4'(i), 4'h0, 32'h0);
            chk("abort_readback", bus.rdata, (i < 5) ? 32'(32'h200 + i) : 32'(32'h100 + i));
        end

        // Random mix of CPU accesses and line transfers
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 5))
                0: begin start_xfer(1'b0, 1'($urandom), 6'($urandom)); drain(400); end
                1: begin start_xfer(1'b1, 1'($urandom), 6'($urandom)); drain(400); end
                default: cpu(1'($urandom), 6'($urandom), 4'($urandom), 4'($urandom), $urandom);
            endcase
            if ($urandom_range(0, 3) == 0) cycle();
        end
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
